gullfaxi_collector: RTL and testbench
=====================================

// Module: gullfaxi_collector
// PURPOSE
//  Receiving end of the Gullfaxi output-port interface (start/length/data/end/req/grant).
//  Arbitrates three requesting switch ports round-robin and grants one only when its whole packet fits.
//  Stores granted packets in a byte FIFO and streams them downstream on valid/ready with source tag.
// PARAMETERS
//  DEPTH      64   FIFO capacity in bytes (power of two)
//  LOGDEPTH   6    log2(DEPTH)
//  START_TO   15   max cycles from grant to start before grant is abandoned
// PORTS
//  clk        in   1  clock; all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  Pk_start   in   1  (k=0..2) first byte of packet on Pk_data
//  Pk_length  in   6  packet length in bytes, valid while Pk_req
//  Pk_data    in   8  packet byte, one per cycle from start through end
//  Pk_end     in   1  last byte of packet on Pk_data
//  Pk_req     in   1  port k holds a packet of Pk_length bytes
//  Pk_grant   out  1  one-cycle grant pulse to port k
//  Q_valid    out  1  byte available on Q_data
//  Q_data     out  8  buffered byte
//  Q_end      out  1  Q_data is last byte of its packet
//  Q_src      out  2  source port (0..2) of the packet
//  Q_ready    in   1  downstream accepts; transfer when Q_valid & Q_ready
//  err        out  1  one-cycle protocol-error pulse
// BEHAVIOUR
//  Reset: all Pk_grant=0, Q_valid=0, Q_data=0, Q_end=0, Q_src=0, err=0; FIFO emptied, rr pointer=0, state IDLE.
//  Credit counter cred (LOGDEPTH+1 bits) = stored bytes + outstanding reservation; free = DEPTH-cred.
//  FSM:
//   IDLE: scan ports starting at rr pointer; first k with Pk_req & Pk_length!=0 & Pk_length<=free wins.
//     Winner: latch port/length, cred+=length, Pk_grant=1 next cycle, rr pointer=k+1 mod 3, go WAIT_START.
//     Pk_req with Pk_length==0: err pulse, rr pointer moves past k, no grant.
//     Winner that does not fit blocks lower-priority ports (no bypass) until free suffices.
//   WAIT_START: grant high during the first cycle only; reqs ignored (sender keeps req 1 cycle after grant).
//     Start on latched port: write byte, cnt=1; with end also asserted -> IDLE, else RECV.
//     Start or end on a non-latched port: err, ignored.
//     START_TO cycles without start: cred-=length, err, IDLE.
//   RECV: write Pk_data of latched port every cycle, cnt++; on Pk_end -> IDLE.
//     Byte beyond length: dropped, err, stay until end.
//     End with cnt<length: cred-=(length-cnt), err.
//  FIFO: write latency 1 cycle -> byte at FIFO tail; Q_valid the cycle after write when FIFO was empty.
//  Q_* held stable while Q_valid & !Q_ready; each byte carries end flag and source tag.
//  Pop: cred-=1; release and pop in the same cycle combine arithmetically (single update).
//  Pointers wrap mod DEPTH; grant logic keeps cred<=DEPTH, so no overflow path exists.
//  Back-to-back: a new grant can issue the cycle after return to IDLE; packets never interleave in FIFO.
//  Reset mid-packet: everything discarded, state IDLE, no grant issued that cycle.
// TESTING
//  P1_req, len=4, bytes A0..A3, Q_ready=1 -> P1_grant pulse 1 cycle; Q: A0..A3, Q_end on A3, Q_src=1.
//  P0,P1,P2 req at once, len=2 each -> grants in order 0,1,2; next round starts at 0 after 2.
//  Q_ready=0; 60 bytes buffered; P2 req len=5 -> no grant; pop 1 byte -> grant follows.
//  Len=1 packet (start+end same cycle) -> single Q byte with Q_end=1; FSM back in IDLE.
//  Grant with no start for 15 cycles -> err pulse; cred restored; next req granted.
//  Reset asserted mid-RECV (len=10, cnt=5) -> Q_valid=0, FIFO empty, grants restart from port 0.

Source files
------------

// File: rtl/gullfaxi_collector_if.sv
// rtl/gullfaxi_collector_if.sv - Gullfaxi switch-port and queue-side signal bundle
// The master side is the switch ports plus the downstream sink; the slave side is the collector.
interface gullfaxi_collector_if;
    logic [2:0]      p_start;
    logic [2:0][5:0] p_length;
    logic [2:0][7:0] p_data;
    logic [2:0]      p_end;
    logic [2:0]      p_req;
    logic [2:0]      p_grant;
    logic            q_valid;
    logic [7:0]      q_data;
    logic            q_end;
    logic [1:0]      q_src;
    logic            q_ready;

    modport master (
        output p_start, p_length, p_data, p_end, p_req, q_ready,
        input  p_grant, q_valid, q_data, q_end, q_src
    );
    modport slave (
        input  p_start, p_length, p_data, p_end, p_req, q_ready,
        output p_grant, q_valid, q_data, q_end, q_src
    );
endinterface

// File: rtl/gullfaxi_collector.sv
// rtl/gullfaxi_collector.sv - Gullfaxi three-port packet collector with credit-checked byte FIFO
// Ports are granted round-robin only when their whole packet fits; bytes leave tagged with source and end flag.
module gullfaxi_collector #(
    parameter int DEPTH    = 64,
    parameter int LOGDEPTH = 6,
    parameter int START_TO = 15
) (
    input  logic                clk,
    input  logic                reset,
    gullfaxi_collector_if.slave bus,
    output logic                err
);
    localparam int CW = LOGDEPTH + 1;
    localparam int TW = (START_TO > 1) ? $clog2(START_TO) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_START, RECV} state_t;

    state_t              state;
    logic [1:0]          rr, port, win, cand;
    logic [5:0]          len, cnt, cnt_w, win_len;
    logic [TW-1:0]       tmr;
    logic [CW-1:0]       cred, free, add, rel, mcnt;
    logic [2:0]          grant;
    logic                hit, fits, bad, done, timeout, pop;
    logic                cur_start, cur_end, wr_en, wr_end;
    logic                load, mem_rd, mem_wr, bypass;
    logic [10:0]         mem [DEPTH];
    logic [10:0]         wr_word;
    logic [LOGDEPTH-1:0] rd_ptr, wr_ptr;
    logic                q_valid, q_end;
    logic [7:0]          q_data;
    logic [1:0]          q_src;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign cur_start = bus.p_start[port];
    assign cur_end   = bus.p_end[port];
    assign free      = CW'(DEPTH) - cred;
    assign pop       = q_valid & bus.q_ready;
    assign wr_word   = {port, wr_end, bus.p_data[port]};

    // Only the first requester from rr competes; if it does not fit yet it holds the others off.
    always_comb begin
        hit  = 1'b0;
        win  = 2'd0;
        cand = rr;
        for (int i = 0; i < 3; i++) begin
            if (!hit && bus.p_req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
            cand = next_port(cand);
        end
        win_len = bus.p_length[win];
        fits    = (win_len != 6'd0) && (CW'(win_len) <= free);
    end

    always_comb begin
        wr_en   = 1'b0;
        bad     = 1'b0;
        add     = '0;
        rel     = '0;
        done    = 1'b0;
        timeout = 1'b0;
        cnt_w   = cnt;
        case (state)
            IDLE: begin
                if (hit && win_len == 6'd0) bad = 1'b1;
                else if (hit && fits)      add = CW'(win_len);
            end
            WAIT_START: begin
                bad = |((bus.p_start | bus.p_end) & ~(3'b001 << port));
                if (cur_start) begin
                    wr_en = 1'b1;
                    cnt_w = 6'd1;
                    done  = cur_end;
                end else if (tmr == TW'(START_TO - 1)) begin
                    timeout = 1'b1;
                    bad     = 1'b1;
                    rel     = CW'(len);
                end
            end
            RECV: begin
                if (cnt < len) begin
                    wr_en = 1'b1;
                    cnt_w = cnt + 6'd1;
                end else begin
                    bad = 1'b1;
                end
                done = cur_end;
            end
            default: ;
        endcase
        // A short packet gives back the reservation it never used.
        if (done && cnt_w < len) begin
            bad = 1'b1;
            rel = CW'(len - cnt_w);
        end
        wr_end = cur_end | (cnt_w == len);
    end

    always_comb begin
        load   = !q_valid || bus.q_ready;
        mem_rd = load && (mcnt != '0);
        bypass = load && (mcnt == '0) && wr_en;
        mem_wr = wr_en && !bypass;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr    <= 2'd0;
            port  <= 2'd0;
            len   <= 6'd0;
            cnt   <= 6'd0;
            tmr   <= '0;
            grant <= 3'b000;
            err   <= 1'b0;
            cred  <= '0;
        end else begin
            grant <= 3'b000;
            err   <= bad;
            cred  <= cred + add - rel - CW'(pop);
            case (state)
                IDLE: begin
                    if (hit && win_len == 6'd0) begin
                        rr <= next_port(win);
                    end else if (hit && fits) begin
                        port  <= win;
                        len   <= win_len;
                        rr    <= next_port(win);
                        grant <= 3'b001 << win;
                        tmr   <= '0;
                        state <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (cur_start) begin
                        cnt   <= cnt_w;
                        state <= cur_end ? IDLE : RECV;
                    end else if (timeout) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                RECV: begin
                    cnt <= cnt_w;
                    if (cur_end) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr] <= wr_word;
    end

    // The output register is the FIFO head, so an empty FIFO presents a byte the cycle after it is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            mcnt    <= '0;
            q_valid <= 1'b0;
            q_data  <= 8'd0;
            q_end   <= 1'b0;
            q_src   <= 2'd0;
        end else begin
            if (mem_rd) begin
                {q_src, q_end, q_data} <= mem[rd_ptr];
                q_valid                <= 1'b1;
                rd_ptr                 <= rd_ptr + LOGDEPTH'(1);
            end else if (bypass) begin
                {q_src, q_end, q_data} <= wr_word;
                q_valid                <= 1'b1;
            end else if (load) begin
                q_valid <= 1'b0;
            end
            if (mem_wr) wr_ptr <= wr_ptr + LOGDEPTH'(1);
            mcnt <= mcnt + CW'(mem_wr) - CW'(mem_rd);
        end
    end

    assign bus.p_grant = grant;
    assign bus.q_valid = q_valid;
    assign bus.q_data  = q_data;
    assign bus.q_end   = q_end;
    assign bus.q_src   = q_src;
endmodule

// File: tb/tb_gullfaxi_collector.sv
// tb/tb_gullfaxi_collector.sv - scoreboard bench for gullfaxi_collector
module tb_gullfaxi_collector;
    logic clk = 1'b0;
    logic reset;
    logic err;
    always #5 clk = ~clk;

    gullfaxi_collector_if bus();
    gullfaxi_collector #(.DEPTH(64), .LOGDEPTH(6), .START_TO(15)) dut (
        .clk(clk), .reset(reset), .bus(bus), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic [10:0] exp_q[$];
    int m_rr = 0;
    bit pend[3];
    int plen[3];
    int pn[3];
    bit rnd_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int predict();
        int p = m_rr;
        for (int i = 0; i < 3; i++) begin
            if (pend[p]) return p;
            p = (p + 1) % 3;
        end
        return -1;
    endfunction

    task automatic request(input int k, input int len, input int n);
        bus.p_req[k]    = 1'b1;
        bus.p_length[k] = 6'(len);
        plen[k] = len;
        pn[k]   = n;
        pend[k] = 1'b1;
    endtask

    task automatic wait_grant(output int k, input int budget);
        k = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.p_grant != 3'b000) begin
                check("grant_onehot", $countones(bus.p_grant), 1);
                k = bus.p_grant[0] ? 0 : (bus.p_grant[1] ? 1 : 2);
                return;
            end
        end
        check("grant_timeout", 1, 0);
    endtask

    task automatic send(input int k, input int nbytes, input int len, input int delay,
                        input int base, input bit chk_lat);
        logic [7:0] d;
        bit first = 1'b1;
        bus.p_req[k] = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            if (first) begin check("grant_pulse", bus.p_grant, 0); first = 1'b0; end
        end
        for (int b = 0; b < nbytes; b++) begin
            d = (base >= 0) ? 8'(base + b) : 8'($urandom);
            bus.p_data[k]  = d;
            bus.p_start[k] = (b == 0);
            bus.p_end[k]   = (b == nbytes - 1);
            if (b < len) exp_q.push_back({2'(k), ((b == nbytes - 1) || (b == len - 1)), d});
            tick();
            if (first) begin check("grant_pulse", bus.p_grant, 0); first = 1'b0; end
            if (chk_lat && b == 0) check("wr_latency", {bus.q_valid, bus.q_data}, {1'b1, d});
        end
        bus.p_start[k] = 1'b0;
        bus.p_end[k]   = 1'b0;
        if (nbytes > len) err_exp += nbytes - len;
        else if (nbytes < len) err_exp++;
    endtask

    task automatic run_round(input int delay_max);
        int exp_k, k;
        while (pend[0] || pend[1] || pend[2]) begin
            exp_k = predict();
            wait_grant(k, 3000);
            if (k < 0) return;
            check("grant_port", k, exp_k);
            m_rr = (k + 1) % 3;
            pend[k] = 1'b0;
            send(k, pn[k], plen[k], $urandom_range(delay_max, 0), -1, 1'b0);
        end
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 3000) begin tick(); i++; end
        tick();
        tick();
        check("drain_empty", {(exp_q.size() != 0), bus.q_valid}, 0);
    endtask

    initial begin
        logic [10:0] w, hold_w;
        bit hold_v;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (err) err_seen++;
                if (hold_v) check("q_hold", {bus.q_valid, bus.q_src, bus.q_end, bus.q_data}, {1'b1, hold_w});
                if (bus.q_valid && bus.q_ready) begin
                    if (exp_q.size() == 0) begin
                        check("q_extra", {1'b1, bus.q_src, bus.q_end, bus.q_data}, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("q_byte", {bus.q_src, bus.q_end, bus.q_data}, w);
                    end
                end
                hold_v = bus.q_valid && !bus.q_ready;
                hold_w = {bus.q_src, bus.q_end, bus.q_data};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.q_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int k, len, n, seen;
        reset        = 1'b1;
        bus.p_start  = '0;
        bus.p_end    = '0;
        bus.p_req    = '0;
        bus.p_length = '0;
        bus.p_data   = '0;
        bus.q_ready  = 1'b0;
        repeat (3) tick();
        check("rst_grant", bus.p_grant, 0);
        check("rst_qvalid", bus.q_valid, 0);
        check("rst_qdata", bus.q_data, 0);
        check("rst_qend", bus.q_end, 0);
        check("rst_qsrc", bus.q_src, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        // Single packet from port 1 with known bytes.
        bus.q_ready = 1'b1;
        request(1, 4, 4);
        wait_grant(k, 20);
        check("p1_port", k, predict());
        m_rr = (k + 1) % 3;
        pend[1] = 1'b0;
        send(1, 4, 4, 0, 8'hA0, 1'b1);
        drain();

        // Simultaneous requests, two rounds.
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 3; p++) request(p, 2, 2);
            run_round(2);
        end
        drain();

        // One-byte packet, then a waiting port is granted right after return to IDLE.
        request(0, 1, 1);
        request(1, 3, 3);
        wait_grant(k, 20);
        check("len1_port", k, predict());
        pend[0] = 1'b0;
        m_rr = 1;
        bus.p_req[0]   = 1'b0;
        bus.p_data[0]  = 8'h5A;
        bus.p_start[0] = 1'b1;
        bus.p_end[0]   = 1'b1;
        exp_q.push_back({2'd0, 1'b1, 8'h5A});
        tick();
        check("len1_grant_pulse", bus.p_grant, 0);
        bus.p_start[0] = 1'b0;
        bus.p_end[0]   = 1'b0;
        tick();
        check("b2b_grant", bus.p_grant, 3'b010);
        pend[1] = 1'b0;
        m_rr = 2;
        send(1, 3, 3, 0, -1, 1'b0);
        drain();

        // Fill 60 bytes with the sink stalled; a 5-byte packet must wait for one pop.
        bus.q_ready = 1'b0;
        request(0, 30, 30);
        request(1, 30, 30);
        run_round(0);
        request(2, 5, 5);
        seen = 0;
        for (int i = 0; i < 30; i++) begin tick(); seen |= int'(bus.p_grant != 3'b000); end
        check("full_no_grant", seen, 0);
        bus.q_ready = 1'b1;
        tick();
        bus.q_ready = 1'b0;
        wait_grant(k, 10);
        check("full_grant_port", k, 2);
        pend[2] = 1'b0;
        m_rr = 0;
        send(2, 5, 5, 0, -1, 1'b0);
        bus.q_ready = 1'b1;
        drain();

        // Grant abandoned after the start timeout; the reservation must come back.
        request(0, 40, 40);
        wait_grant(k, 20);
        check("to_port", k, predict());
        pend[0] = 1'b0;
        bus.p_req[0] = 1'b0;
        m_rr = (k + 1) % 3;
        seen = 0;
        for (int i = 0; i < 14; i++) begin tick(); seen |= int'(err); end
        check("to_early_err", seen, 0);
        tick();
        check("to_err", err, 1);
        err_exp++;
        request(1, 40, 40);
        run_round(3);
        drain();

        // Zero-length request.
        bus.p_req[2]    = 1'b1;
        bus.p_length[2] = 6'd0;
        tick();
        check("zero_err", err, 1);
        err_exp++;
        bus.p_req[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); seen |= int'(bus.p_grant != 3'b000); end
        check("zero_no_grant", seen, 0);
        m_rr = 0;

        // Reset in the middle of a 10-byte packet after 5 bytes.
        bus.q_ready = 1'b0;
        request(0, 10, 10);
        wait_grant(k, 20);
        check("rst_mid_port", k, predict());
        pend[0] = 1'b0;
        bus.p_req[0] = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus.p_data[0]  = 8'(8'h30 + b);
            bus.p_start[0] = (b == 0);
            tick();
        end
        bus.p_start[0] = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_mid_qvalid", bus.q_valid, 0);
        check("rst_mid_grant", bus.p_grant, 0);
        reset = 1'b0;
        m_rr = 0;
        repeat (3) tick();
        check("rst_mid_empty", bus.q_valid, 0);
        request(1, 3, 3);
        request(0, 3, 3);
        bus.q_ready = 1'b1;
        run_round(2);
        drain();

        // Randomised rounds including short and overlong packets.
        rnd_ready = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 3; p++) begin
                if ($urandom % 2 == 0) begin
                    len = $urandom_range(40, 1);
                    n = len;
                    case ($urandom % 8)
                        0: n = len + $urandom_range(3, 1);
                        1: if (len > 1) n = $urandom_range(len - 1, 1);
                        default: ;
                    endcase
                    request(p, len, n);
                end
            end
            if (!(pend[0] || pend[1] || pend[2])) request($urandom % 3, 7, 7);
            run_round(5);
        end
        rnd_ready = 1'b0;
        bus.q_ready = 1'b1;
        drain();
        check("err_count", err_seen, err_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
